rom_rr_arbiter: RTL

- Two-requester round-robin arbiter and sequencer for the shared 16x8 synchronous ROM (cs/rd controlled, registered read, 1-cycle latency).
- Sits between two client blocks and the ROM instance. Owns the ROM cs/rd/addr pins and returns each read result with a one-cycle ack pulse.
- Serialises accesses: one ROM read in flight at a time.

---
 rtl/rom_rr_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter/sequencer giving two clients shared access to a 16x8 registered ROM.
// Optional macro ROM_ADDR_CHECK_EN adds err_a/err_b and suppresses reads beyond VALID_DEPTH.
module rom_rr_arbiter #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned VALID_DEPTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] data_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] data_b,
    output logic              rom_cs,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
`ifdef ROM_ADDR_CHECK_EN
    ,
    output logic              err_a,
    output logic              err_b
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    // Programmed depth must fit the ROM address space.
    if (VALID_DEPTH > (32'd1 << ADDR_W)) begin : g_depth_chk
        $error("VALID_DEPTH exceeds ROM address space");
    end

    state_e              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rom_cs_q, rom_cs_d;
    logic                rom_rd_q, rom_rd_d;
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic [DATA_W-1:0]   data_a_q, data_a_d;
    logic [DATA_W-1:0]   data_b_q, data_b_d;
    logic                busy_q, busy_d;

    logic                elig_a_c;
    logic                elig_b_c;
    logic                pick_c;
    logic [ADDR_W-1:0]   pick_addr_c;
    logic                pick_ok_c;
    logic [DATA_W-1:0]   cap_data_c;

`ifdef ROM_ADDR_CHECK_EN
    logic                inval_q, inval_d;
    logic                err_a_q, err_a_d;
    logic                err_b_q, err_b_d;
`endif

    // Requester whose ack is showing this cycle still holds a stale req; mask it.
    assign elig_a_c    = req_a & ~ack_a_q;
    assign elig_b_c    = req_b & ~ack_b_q;
    assign pick_c      = (elig_a_c & elig_b_c) ? ~last_q : elig_b_c;
    assign pick_addr_c = (pick_c == GNT_B) ? addr_b : addr_a;

`ifdef ROM_ADDR_CHECK_EN
    assign pick_ok_c   = (32'(pick_addr_c) < VALID_DEPTH);
    assign cap_data_c  = inval_q ? '0 : rom_data;
`else
    assign pick_ok_c   = 1'b1;
    assign cap_data_c  = rom_data;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        addr_d   = addr_q;
        rom_cs_d = 1'b0;
        rom_rd_d = 1'b0;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
`ifdef ROM_ADDR_CHECK_EN
        inval_d  = inval_q;
        err_a_d  = 1'b0;
        err_b_d  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (elig_a_c || elig_b_c) begin
                    gnt_d    = pick_c;
                    last_d   = pick_c;
                    addr_d   = pick_addr_c;
                    rom_cs_d = pick_ok_c;
                    rom_rd_d = pick_ok_c;
`ifdef ROM_ADDR_CHECK_EN
                    inval_d  = ~pick_ok_c;
`endif
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (gnt_q == GNT_A) begin
                    ack_a_d  = 1'b1;
                    data_a_d = cap_data_c;
`ifdef ROM_ADDR_CHECK_EN
                    err_a_d  = inval_q;
`endif
                end else begin
                    ack_b_d  = 1'b1;
                    data_b_d = cap_data_c;
`ifdef ROM_ADDR_CHECK_EN
                    err_b_d  = inval_q;
`endif
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= GNT_A;
            last_q   <= GNT_B;
            addr_q   <= '0;
            rom_cs_q <= 1'b0;
            rom_rd_q <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            data_a_q <= '0;
            data_b_q <= '0;
            busy_q   <= 1'b0;
`ifdef ROM_ADDR_CHECK_EN
            inval_q  <= 1'b0;
            err_a_q  <= 1'b0;
            err_b_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            rom_cs_q <= rom_cs_d;
            rom_rd_q <= rom_rd_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            busy_q   <= busy_d;
`ifdef ROM_ADDR_CHECK_EN
            inval_q  <= inval_d;
            err_a_q  <= err_a_d;
            err_b_q  <= err_b_d;
`endif
        end
    end

    assign ack_a    = ack_a_q;
    assign ack_b    = ack_b_q;
    assign data_a   = data_a_q;
    assign data_b   = data_b_q;
    assign rom_cs   = rom_cs_q;
    assign rom_rd   = rom_rd_q;
    assign rom_addr = addr_q;
    assign busy     = busy_q;
`ifdef ROM_ADDR_CHECK_EN
    assign err_a    = err_a_q;
    assign err_b    = err_b_q;
`endif

endmodule
